// File: rtl/memory_controller_pkg.sv
`timescale 1ns/1ps
// Shared constants for the memory controller: FSM encoding, access sizes and the UART window base.
package memory_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LREAD  = 2'd2,
    ST_LWRITE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // Index of the final byte of an access; unused encoding 3 is treated as a word.
  function automatic logic [2:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_index = 3'd0;
      SIZE_HALF: last_index = 3'd1;
      default:   last_index = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
`timescale 1ns/1ps
// Bus bundle between the memory controller, the RAM/UART port, the fetch unit and the LSB.
interface memory_controller_if;
  logic        rdy_in;
  logic        roll_back;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        fetch_start;
  logic [31:0] pc_in;
  logic        finish_fetch;
  logic [31:0] instruction_out;
  logic [31:0] instruction_pc_out;
  logic        is_idle;
  logic        lsb_req;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  modport master (
    input  rdy_in, roll_back, io_buffer_full, mem_din,
    input  fetch_start, pc_in,
    input  lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
    output mem_dout, mem_a, mem_wr,
    output finish_fetch, instruction_out, instruction_pc_out, is_idle,
    output lsb_done, lsb_rdata
  );

  modport slave (
    output rdy_in, roll_back, io_buffer_full, mem_din,
    output fetch_start, pc_in,
    output lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  finish_fetch, instruction_out, instruction_pc_out, is_idle,
    input  lsb_done, lsb_rdata
  );
endinterface

// File: rtl/memory_controller.sv
`timescale 1ns/1ps
// Arbitrates instruction fetches and LSB loads/stores onto a byte-wide RAM/UART bus,
// serialising multi-byte accesses little-endian at one byte per cycle.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  memory_controller_if.master bus
);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_inc, last;
  logic [31:0] addr, wdata, acc, word, addr_nxt;
  logic        wr_q, io_stall, at_last;

  assign cnt_inc  = cnt + 3'd1;
  assign at_last  = (cnt == last);
  assign addr_nxt = addr + 32'(cnt_inc);
  assign io_stall = (state == ST_LWRITE) && (addr >= IO_BASE) && bus.io_buffer_full;
  // wr_q marks a pending write byte; the strobe is withheld during a pause or a UART stall.
  assign bus.mem_wr  = wr_q && bus.rdy_in && !io_stall;
  assign bus.is_idle = (state == ST_IDLE);

  always_comb begin
    word = acc;
    word[{cnt, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.lsb_req)
          state_nxt = bus.lsb_wr ? ST_LWRITE : ST_LREAD;
        else if (bus.fetch_start && !bus.roll_back)
          state_nxt = ST_IFETCH;
      end
      ST_IFETCH: if (bus.roll_back || at_last) state_nxt = ST_IDLE;
      ST_LREAD:  if (at_last) state_nxt = ST_IDLE;
      ST_LWRITE: if (at_last && !io_stall) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)          state <= ST_IDLE;
    else if (bus.rdy_in)  state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt                    <= '0;
      last                   <= '0;
      addr                   <= '0;
      wdata                  <= '0;
      acc                    <= '0;
      wr_q                   <= 1'b0;
      bus.mem_a              <= '0;
      bus.mem_dout           <= '0;
      bus.finish_fetch       <= 1'b0;
      bus.lsb_done           <= 1'b0;
      bus.instruction_out    <= '0;
      bus.instruction_pc_out <= '0;
      bus.lsb_rdata          <= '0;
    end else if (bus.rdy_in) begin
      bus.finish_fetch <= 1'b0;
      bus.lsb_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          acc <= '0;
          if (bus.lsb_req) begin
            addr         <= bus.lsb_addr;
            last         <= last_index(bus.lsb_size);
            wdata        <= bus.lsb_wdata;
            bus.mem_a    <= bus.lsb_addr;
            bus.mem_dout <= bus.lsb_wdata[7:0];
            wr_q         <= bus.lsb_wr;
          end else if (bus.fetch_start && !bus.roll_back) begin
            addr      <= bus.pc_in;
            last      <= 3'd3;
            bus.mem_a <= bus.pc_in;
          end
        end
        ST_IFETCH, ST_LREAD: begin
          // A flushed fetch simply stops; IDLE clears the partial word on the way back in.
          if (!(state == ST_IFETCH && bus.roll_back)) begin
            if (at_last) begin
              if (state == ST_IFETCH) begin
                bus.finish_fetch       <= 1'b1;
                bus.instruction_out    <= word;
                bus.instruction_pc_out <= addr;
              end else begin
                bus.lsb_done  <= 1'b1;
                bus.lsb_rdata <= word;
              end
            end else begin
              acc       <= word;
              cnt       <= cnt_inc;
              bus.mem_a <= addr_nxt;
            end
          end
        end
        ST_LWRITE: begin
          if (!io_stall) begin
            if (at_last) begin
              wr_q         <= 1'b0;
              bus.lsb_done <= 1'b1;
            end else begin
              cnt          <= cnt_inc;
              bus.mem_a    <= addr_nxt;
              bus.mem_dout <= wdata[{cnt_inc, 3'b000} +: 8];
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
// Directed bench for memory_controller: fetch, arbitration, flush, load/store sizes, UART stall, pause and reset.
module tb_memory_controller;

  logic clk_in = 1'b0;
  logic rst_in;
  memory_controller_if bus ();

  memory_controller dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic [7:0]  ram [0:65535];
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  // Asynchronous-read RAM; the UART window above 0x30000 is not backed by storage.
  assign bus.mem_din = ram[bus.mem_a[15:0]];
  always @(posedge clk_in) begin
    if (load_en) ram[load_addr] = load_data;
    else if (bus.mem_wr && bus.mem_a < 32'h0003_0000) ram[bus.mem_a[15:0]] = bus.mem_dout;
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_req();
    bus.lsb_req     = 1'b0;
    bus.fetch_start = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    next_cycle();
    load_en = 1'b0;
  endtask

  task automatic lsb_issue(input logic wr, input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    bus.lsb_req = 1'b1; bus.lsb_wr = wr; bus.lsb_size = size; bus.lsb_addr = a; bus.lsb_wdata = d;
  endtask

  task automatic test_reset();
    logic [138:0] obs;
    @(negedge clk_in);
    obs = {bus.mem_wr, bus.mem_a, bus.mem_dout, bus.finish_fetch, bus.lsb_done,
           bus.instruction_out, bus.instruction_pc_out, bus.lsb_rdata};
    vectors++; if (obs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", obs); end
    vectors++; if (bus.is_idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", bus.is_idle); end
    next_cycle();
    rst_in = 1'b1;
  endtask

  task automatic test_fetch();
    next_cycle();
    bus.fetch_start = 1'b1; bus.pc_in = 32'h1000;
    next_cycle();
    clear_req();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      vectors++;
      if ({bus.mem_a, bus.mem_wr, bus.finish_fetch, bus.is_idle} !== {32'h1000 + 32'(k - 1), 3'b000}) begin
        miscompares++;
        $display("FAIL fetch_addr_k%0d: got a=%h wr=%b ff=%b idle=%b want a=%h 0 0 0", k - 1,
                 bus.mem_a, bus.mem_wr, bus.finish_fetch, bus.is_idle, 32'h1000 + 32'(k - 1));
      end
      next_cycle();
    end
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.is_idle, bus.instruction_out, bus.instruction_pc_out} !== {2'b11, 32'h0010_0513, 32'h1000}) begin
      miscompares++;
      $display("FAIL fetch_done: got ff=%b idle=%b ins=%h pc=%h want 1 1 00100513 00001000",
               bus.finish_fetch, bus.is_idle, bus.instruction_out, bus.instruction_pc_out);
    end
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.instruction_out} !== {1'b0, 32'h0010_0513}) begin
      miscompares++;
      $display("FAIL fetch_hold: got ff=%b ins=%h want 0 00100513", bus.finish_fetch, bus.instruction_out);
    end
  endtask

  task automatic test_arbitration();
    next_cycle();
    lsb_issue(1'b0, 2'd2, 32'h2000, 32'h0);
    bus.fetch_start = 1'b1; bus.pc_in = 32'h1000;
    next_cycle();
    bus.lsb_req = 1'b0;
    @(negedge clk_in);
    vectors++; if (bus.mem_a !== 32'h2000) begin miscompares++; $display("FAIL arb_first_addr: got %h want 00002000", bus.mem_a); end
    repeat (4) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.finish_fetch, bus.lsb_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL arb_load_done: got done=%b ff=%b rdata=%h want 1 0 deadbeef", bus.lsb_done, bus.finish_fetch, bus.lsb_rdata);
    end
    next_cycle();
    clear_req();
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_a, bus.is_idle} !== {32'h1000, 1'b0}) begin
      miscompares++;
      $display("FAIL arb_fetch_start: got a=%h idle=%b want 00001000 0", bus.mem_a, bus.is_idle);
    end
    repeat (4) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.instruction_out} !== {1'b1, 32'h0010_0513}) begin
      miscompares++;
      $display("FAIL arb_fetch_done: got ff=%b ins=%h want 1 00100513", bus.finish_fetch, bus.instruction_out);
    end
  endtask

  task automatic test_rollback();
    next_cycle();
    bus.fetch_start = 1'b1; bus.pc_in = 32'h1004;
    next_cycle();
    clear_req();
    repeat (2) next_cycle();
    bus.roll_back = 1'b1;
    @(negedge clk_in);
    vectors++; if (bus.mem_a !== 32'h1006) begin miscompares++; $display("FAIL rb_cycle3_addr: got %h want 00001006", bus.mem_a); end
    next_cycle();
    bus.roll_back = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.is_idle, bus.finish_fetch} !== 2'b10) begin
      miscompares++;
      $display("FAIL rb_abort: got idle=%b ff=%b want 1 0", bus.is_idle, bus.finish_fetch);
    end
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.instruction_out} !== {1'b0, 32'h0010_0513}) begin
      miscompares++;
      $display("FAIL rb_no_finish: got ff=%b ins=%h want 0 00100513", bus.finish_fetch, bus.instruction_out);
    end
    next_cycle();
    bus.fetch_start = 1'b1; bus.pc_in = 32'h1004;
    next_cycle();
    clear_req();
    repeat (4) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.instruction_out, bus.instruction_pc_out} !== {1'b1, 32'h0050_0093, 32'h1004}) begin
      miscompares++;
      $display("FAIL rb_refetch: got ff=%b ins=%h pc=%h want 1 00500093 00001004",
               bus.finish_fetch, bus.instruction_out, bus.instruction_pc_out);
    end
  endtask

  task automatic test_rollback_coincide();
    next_cycle();
    bus.fetch_start = 1'b1; bus.pc_in = 32'h1000;
    next_cycle();
    clear_req();
    repeat (3) next_cycle();
    bus.roll_back = 1'b1;
    @(negedge clk_in);
    vectors++; if (bus.mem_a !== 32'h1003) begin miscompares++; $display("FAIL rbc_last_addr: got %h want 00001003", bus.mem_a); end
    next_cycle();
    bus.roll_back = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.finish_fetch, bus.is_idle, bus.instruction_out} !== {2'b01, 32'h0050_0093}) begin
      miscompares++;
      $display("FAIL rbc_suppress: got ff=%b idle=%b ins=%h want 0 1 00500093", bus.finish_fetch, bus.is_idle, bus.instruction_out);
    end
  endtask

  task automatic test_load_sizes();
    next_cycle();
    lsb_issue(1'b0, 2'd0, 32'h2003, 32'h0);
    next_cycle();
    bus.lsb_req = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_a, bus.lsb_done} !== {32'h2003, 1'b0}) begin
      miscompares++;
      $display("FAIL lb_addr: got a=%h done=%b want 00002003 0", bus.mem_a, bus.lsb_done);
    end
    next_cycle();
    lsb_issue(1'b0, 2'd1, 32'h2002, 32'h0);
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'h0000_00DE}) begin
      miscompares++;
      $display("FAIL lb_done: got done=%b rdata=%h want 1 000000de", bus.lsb_done, bus.lsb_rdata);
    end
    next_cycle();
    bus.lsb_req = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_a, bus.lsb_done} !== {32'h2002, 1'b0}) begin
      miscompares++;
      $display("FAIL lh_b2b_addr: got a=%h done=%b want 00002002 0", bus.mem_a, bus.lsb_done);
    end
    repeat (2) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'h0000_DEAD}) begin
      miscompares++;
      $display("FAIL lh_done: got done=%b rdata=%h want 1 0000dead", bus.lsb_done, bus.lsb_rdata);
    end
  endtask

  task automatic test_store_half();
    next_cycle();
    lsb_issue(1'b1, 2'd1, 32'h20, 32'h0000_BEEF);
    next_cycle();
    bus.lsb_req = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h20, 8'hEF}) begin
      miscompares++;
      $display("FAIL sh_byte0: got wr=%b a=%h d=%h want 1 00000020 ef", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h21, 8'hBE}) begin
      miscompares++;
      $display("FAIL sh_byte1: got wr=%b a=%h d=%h want 1 00000021 be", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.lsb_done} !== 2'b01) begin
      miscompares++;
      $display("FAIL sh_done: got wr=%b done=%b want 0 1", bus.mem_wr, bus.lsb_done);
    end
    next_cycle();
    lsb_issue(1'b0, 2'd1, 32'h20, 32'h0);
    next_cycle();
    bus.lsb_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'h0000_BEEF}) begin
      miscompares++;
      $display("FAIL sh_readback: got done=%b rdata=%h want 1 0000beef", bus.lsb_done, bus.lsb_rdata);
    end
  endtask

  task automatic test_io_stall();
    next_cycle();
    lsb_issue(1'b1, 2'd0, 32'h0003_0000, 32'h41);
    next_cycle();
    bus.lsb_req = 1'b0;
    bus.io_buffer_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      vectors++;
      if ({bus.mem_wr, bus.mem_a, bus.lsb_done} !== {1'b0, 32'h0003_0000, 1'b0}) begin
        miscompares++;
        $display("FAIL io_stall_c%0d: got wr=%b a=%h done=%b want 0 00030000 0", k, bus.mem_wr, bus.mem_a, bus.lsb_done);
      end
      next_cycle();
    end
    bus.io_buffer_full = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h0003_0000, 8'h41}) begin
      miscompares++;
      $display("FAIL io_write: got wr=%b a=%h d=%h want 1 00030000 41", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.lsb_done} !== 2'b01) begin
      miscompares++;
      $display("FAIL io_done: got wr=%b done=%b want 0 1", bus.mem_wr, bus.lsb_done);
    end
  endtask

  task automatic test_pause_read();
    next_cycle();
    lsb_issue(1'b0, 2'd2, 32'h2000, 32'h0);
    next_cycle();
    bus.lsb_req = 1'b0;
    next_cycle();
    bus.rdy_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      vectors++;
      if ({bus.mem_a, bus.lsb_done} !== {32'h2001, 1'b0}) begin
        miscompares++;
        $display("FAIL pr_frozen: got a=%h done=%b want 00002001 0", bus.mem_a, bus.lsb_done);
      end
      next_cycle();
    end
    bus.rdy_in = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL pr_done: got done=%b rdata=%h want 1 deadbeef", bus.lsb_done, bus.lsb_rdata);
    end
  endtask

  task automatic test_pause_write();
    next_cycle();
    lsb_issue(1'b1, 2'd2, 32'h40, 32'hCAFE_F00D);
    next_cycle();
    bus.lsb_req = 1'b0;
    next_cycle();
    bus.rdy_in = 1'b0;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.mem_a} !== {1'b0, 32'h41}) begin
      miscompares++;
      $display("FAIL pw_paused: got wr=%b a=%h want 0 00000041", bus.mem_wr, bus.mem_a);
    end
    next_cycle();
    bus.rdy_in = 1'b1;
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h41, 8'hF0}) begin
      miscompares++;
      $display("FAIL pw_reissue: got wr=%b a=%h d=%h want 1 00000041 f0", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    repeat (3) next_cycle();
    @(negedge clk_in);
    vectors++; if (bus.lsb_done !== 1'b1) begin miscompares++; $display("FAIL pw_done: got %b want 1", bus.lsb_done); end
    next_cycle();
    lsb_issue(1'b0, 2'd2, 32'h40, 32'h0);
    next_cycle();
    bus.lsb_req = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL pw_readback: got done=%b rdata=%h want 1 cafef00d", bus.lsb_done, bus.lsb_rdata);
    end
  endtask

  task automatic test_wrap();
    next_cycle();
    lsb_issue(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);
    next_cycle();
    bus.lsb_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk_in);
    vectors++; if (bus.mem_a !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h want 00000000", bus.mem_a); end
    repeat (2) next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.lsb_done, bus.lsb_rdata} !== {1'b1, 32'h4433_2211}) begin
      miscompares++;
      $display("FAIL wrap_data: got done=%b rdata=%h want 1 44332211", bus.lsb_done, bus.lsb_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    next_cycle();
    lsb_issue(1'b1, 2'd2, 32'h50, 32'h1122_3344);
    next_cycle();
    bus.lsb_req = 1'b0;
    next_cycle();
    @(negedge clk_in);
    vectors++; if (bus.mem_wr !== 1'b1) begin miscompares++; $display("FAIL rst_pre_write: got %b want 1", bus.mem_wr); end
    #2 rst_in = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_wr, bus.is_idle, bus.mem_a, bus.mem_dout} !== {2'b01, 32'h0, 8'h0}) begin
      miscompares++;
      $display("FAIL rst_async: got wr=%b idle=%b a=%h d=%h want 0 1 0 0", bus.mem_wr, bus.is_idle, bus.mem_a, bus.mem_dout);
    end
    next_cycle();
    rst_in = 1'b1;
    next_cycle();
    @(negedge clk_in);
    vectors++;
    if ({bus.mem_wr, bus.is_idle, bus.lsb_done} !== 3'b010) begin
      miscompares++;
      $display("FAIL rst_after: got wr=%b idle=%b done=%b want 0 1 0", bus.mem_wr, bus.is_idle, bus.lsb_done);
    end
  endtask

  initial begin
    rst_in = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus.rdy_in = 1'b1; bus.roll_back = 1'b0; bus.io_buffer_full = 1'b0;
    bus.fetch_start = 1'b0; bus.pc_in = '0;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_size = '0; bus.lsb_wdata = '0;
    preload(16'h1000, 8'h13); preload(16'h1001, 8'h05); preload(16'h1002, 8'h10); preload(16'h1003, 8'h00);
    preload(16'h1004, 8'h93); preload(16'h1005, 8'h00); preload(16'h1006, 8'h50); preload(16'h1007, 8'h00);
    preload(16'h2000, 8'hEF); preload(16'h2001, 8'hBE); preload(16'h2002, 8'hAD); preload(16'h2003, 8'hDE);
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'h22); preload(16'h0000, 8'h33); preload(16'h0001, 8'h44);
    test_reset();
    test_fetch();
    test_arbitration();
    test_rollback();
    test_rollback_coincide();
    test_load_sizes();
    test_store_half();
    test_io_stall();
    test_pause_read();
    test_pause_write();
    test_wrap();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
